microcode_sequencer: RTL and testbench

Fetch-and-sequence controller for the 512-word microcode EPROM. It drives the EPROM address and active-low chip/output enables, and waits a parameterised number of clocks for the asynchronous ROM access. It then latches the returned word into the microinstruction register and computes the next micro-PC from sequencing fields in that word. It sits between the microcode EPROM and the CPU control decode, and provides jump, conditional branch, opcode dispatch, a 4-deep call/return stack, halt, and stall.

---
 rtl/microcode_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_microcode_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/microcode_sequencer.sv
// rtl/microcode_sequencer.sv - microcode EPROM fetch and micro-PC sequencer
module microcode_sequencer #(
    parameter int         WIDTH       = 64,
    parameter int         WAIT_CYCLES = 3,
    parameter logic [8:0] RESET_ADDR  = 9'd0,
    parameter int         STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic             _rom_cs,
    output logic             _rom_oe,
    output logic [8:0]       rom_addr,
    input  logic [WIDTH-1:0] rom_data,
    input  logic [7:0]       cond,
    input  logic [8:0]       dispatch_addr,
    input  logic             stall,
    output logic [WIDTH-1:0] uinst,
    output logic             uinst_valid,
    output logic [8:0]       upc,
    output logic             halted,
    output logic             fault
);

    localparam int         SPW       = $clog2(STACK_DEPTH + 1);
    localparam int         AW        = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    localparam logic [2:0] OP_NEXT     = 3'd0;
    localparam logic [2:0] OP_JUMP     = 3'd1;
    localparam logic [2:0] OP_BRT      = 3'd2;
    localparam logic [2:0] OP_BRF      = 3'd3;
    localparam logic [2:0] OP_CALL     = 3'd4;
    localparam logic [2:0] OP_RET      = 3'd5;
    localparam logic [2:0] OP_DISPATCH = 3'd6;
    localparam logic [2:0] OP_HALT     = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic [3:0] wait_next;
    logic [8:0] upc_next;
    logic       push;
    logic       pop;
    logic       latch;
    logic       set_halt;
    logic       set_fault;

    logic [SPW-1:0] sp;
    logic [8:0]     stack [STACK_DEPTH];
    logic [AW-1:0]  push_idx;
    logic [AW-1:0]  pop_idx;

    logic [2:0] op;
    logic [8:0] target;
    logic [2:0] csel;
    logic [8:0] inc;

    assign op       = uinst[WIDTH-1 -: 3];
    assign target   = uinst[WIDTH-4 -: 9];
    assign csel     = uinst[WIDTH-13 -: 3];
    assign inc      = upc + 9'd1;
    assign push_idx = AW'(sp);
    assign pop_idx  = AW'(sp - SPW'(1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, wait counting and micro-PC selection
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        upc_next   = upc;
        push       = 1'b0;
        pop        = 1'b0;
        latch      = 1'b0;
        set_halt   = 1'b0;
        set_fault  = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
                wait_next  = 4'd1;
            end
            S_FETCH: begin
                if (wait_cnt == WAIT_LAST) begin
                    latch      = 1'b1;
                    state_next = S_EXEC;
                end else begin
                    wait_next = wait_cnt + 4'd1;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    state_next = S_FETCH;
                    wait_next  = 4'd1;
                    case (op)
                        OP_NEXT:     upc_next = inc;
                        OP_JUMP:     upc_next = target;
                        OP_BRT:      upc_next = cond[csel] ? target : inc;
                        OP_BRF:      upc_next = cond[csel] ? inc : target;
                        OP_CALL: begin
                            if (sp == SP_FULL) begin
                                set_fault  = 1'b1;
                                set_halt   = 1'b1;
                                state_next = S_HALT;
                            end else begin
                                push     = 1'b1;
                                upc_next = target;
                            end
                        end
                        OP_RET: begin
                            if (sp == '0) begin
                                set_fault  = 1'b1;
                                set_halt   = 1'b1;
                                state_next = S_HALT;
                            end else begin
                                pop      = 1'b1;
                                upc_next = stack[pop_idx];
                            end
                        end
                        OP_DISPATCH: upc_next = dispatch_addr;
                        default: begin
                            set_halt   = 1'b1;
                            state_next = S_HALT;
                        end
                    endcase
                end
            end
            default: begin
                state_next = S_HALT;
            end
        endcase
    end

    // Registered datapath and outputs; enables follow the next state so they rise with the data latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt    <= 4'd0;
            upc         <= RESET_ADDR;
            rom_addr    <= RESET_ADDR;
            _rom_cs     <= 1'b1;
            _rom_oe     <= 1'b1;
            uinst       <= '0;
            uinst_valid <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            sp          <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack[i] <= 9'd0;
            end
        end else begin
            wait_cnt    <= wait_next;
            upc         <= upc_next;
            _rom_cs     <= (state_next != S_FETCH);
            _rom_oe     <= (state_next != S_FETCH);
            uinst_valid <= (state_next == S_EXEC);
            if (state_next == S_FETCH && state != S_FETCH) begin
                rom_addr <= upc_next;
            end
            if (latch) begin
                uinst <= rom_data;
            end
            if (set_halt) begin
                halted <= 1'b1;
            end
            if (set_fault) begin
                fault <= 1'b1;
            end
            if (push) begin
                stack[push_idx] <= inc;
                sp              <= sp + SPW'(1);
            end else if (pop) begin
                sp <= sp - SPW'(1);
            end
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// tb/tb_microcode_sequencer.sv - directed self-checking bench for microcode_sequencer
module tb_microcode_sequencer;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         _rom_cs;
    logic         _rom_oe;
    logic [8:0]   rom_addr;
    logic [W-1:0] rom_data;
    logic [7:0]   cond = 8'd0;
    logic [8:0]   dispatch_addr = 9'd0;
    logic         stall = 1'b0;
    logic [W-1:0] uinst;
    logic         uinst_valid;
    logic [8:0]   upc;
    logic         halted;
    logic         fault;

    logic [W-1:0] rom [512];
    logic [8:0]   trace [$];
    int           n_cmp = 0;
    int           n_err = 0;

    microcode_sequencer #(.WIDTH(W), .WAIT_CYCLES(3), .RESET_ADDR(9'd0), .STACK_DEPTH(4)) dut (
        .clk(clk), .reset(reset), ._rom_cs(_rom_cs), ._rom_oe(_rom_oe), .rom_addr(rom_addr),
        .rom_data(rom_data), .cond(cond), .dispatch_addr(dispatch_addr), .stall(stall),
        .uinst(uinst), .uinst_valid(uinst_valid), .upc(upc), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    assign rom_data = (!_rom_cs && !_rom_oe) ? rom[rom_addr] : {W{1'bx}};

    function automatic logic [W-1:0] mw(input logic [2:0] op, input logic [8:0] tgt,
                                        input logic [2:0] cs, input logic [15:0] tag);
        return {op, tgt, cs, 33'd0, tag};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 512; i++) rom[i] = mw(3'd7, 9'd0, 3'd0, 16'(i));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run(input int max_valid, input int max_cycles);
        int cyc;
        logic timed_out;
        trace.delete();
        cyc = 0;
        timed_out = 1'b0;
        while (1) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (uinst_valid) trace.push_back(upc);
            if (halted || trace.size() >= max_valid) break;
            if (cyc >= max_cycles) begin
                timed_out = 1'b1;
                break;
            end
        end
        check("run_timeout", timed_out, 1'b0);
    endtask

    task automatic branch_case(input string tag, input logic [2:0] op, input logic [7:0] c,
                               input logic [8:0] exp_next);
        clear_rom();
        rom[0] = mw(3'd1, 9'd5, 3'd0, 16'h0);
        rom[5] = mw(op, 9'h40, 3'd2, 16'h5);
        cond = c;
        do_reset();
        run(10, 200);
        check({tag, "_len"}, 64'(trace.size()), 64'd3);
        if (trace.size() == 3) check({tag, "_next"}, 64'(trace[2]), 64'(exp_next));
        cond = 8'd0;
    endtask

    initial begin
        int first_valid;
        int cs_low;
        int run_len;
        int bad_runs;
        int vcnt;
        int bad;
        int edges;
        logic [8:0] vupc [$];

        // sequential NEXT words with timing checks
        clear_rom();
        for (int i = 0; i < 4; i++) rom[i] = mw(3'd0, 9'd0, 3'd0, 16'hA000 + 16'(i));
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cs", _rom_cs, 1'b1);
        check("rst_oe", _rom_oe, 1'b1);
        check("rst_valid", uinst_valid, 1'b0);
        check("rst_upc", upc, 9'd0);
        check("rst_addr", rom_addr, 9'd0);
        check("rst_uinst", uinst, 64'd0);
        check("rst_flags", {halted, fault}, 2'b00);
        reset = 1'b0;
        first_valid = 0; cs_low = 0; run_len = 0; bad_runs = 0; vcnt = 0;
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (!_rom_cs) begin
                run_len++;
                if (e <= 16) cs_low++;
            end else if (run_len != 0) begin
                if (run_len != 3) bad_runs++;
                run_len = 0;
            end
            if (uinst_valid) begin
                if (first_valid == 0) first_valid = e + 1;
                if (e <= 16) begin
                    vcnt++;
                    vupc.push_back(upc);
                end
                if (upc == 9'd2) check("uinst_word2", uinst, rom[2]);
            end
        end
        check("first_valid_cycle", 64'(first_valid), 64'd5);
        check("cs_low_cycles", 64'(cs_low), 64'd12);
        check("cs_run_len", 64'(bad_runs), 64'd0);
        check("valid_count", 64'(vcnt), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < vupc.size()) check("seq_upc", 64'(vupc[i]), 64'(i));
        check("halt_flags", {halted, fault, _rom_cs, _rom_oe, uinst_valid}, 5'b10110);
        check("halt_upc", upc, 9'd4);

        // conditional branches
        branch_case("brt_taken", 3'd2, 8'h04, 9'h40);
        branch_case("brt_fall", 3'd2, 8'hFB, 9'd6);
        branch_case("brf_taken", 3'd3, 8'hFB, 9'h40);
        branch_case("brf_fall", 3'd3, 8'h04, 9'd6);

        // CALL chain overflowing the 4-entry stack
        clear_rom();
        rom[0] = mw(3'd1, 9'h10, 3'd0, 16'h0);
        rom[9'h10] = mw(3'd4, 9'h20, 3'd0, 16'h0);
        rom[9'h20] = mw(3'd4, 9'h30, 3'd0, 16'h0);
        rom[9'h30] = mw(3'd4, 9'h40, 3'd0, 16'h0);
        rom[9'h40] = mw(3'd4, 9'h50, 3'd0, 16'h0);
        rom[9'h50] = mw(3'd4, 9'h60, 3'd0, 16'h0);
        rom[9'h60] = mw(3'd0, 9'h0, 3'd0, 16'h0);
        do_reset();
        run(20, 200);
        check("ovf_flags", {fault, halted}, 2'b11);
        check("ovf_upc", upc, 9'h50);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (!_rom_cs || !_rom_oe || uinst_valid) bad++;
        end
        check("ovf_enables_high", 64'(bad), 64'd0);

        // CALL then RET
        clear_rom();
        rom[0] = mw(3'd1, 9'h10, 3'd0, 16'h0);
        rom[9'h10] = mw(3'd4, 9'h70, 3'd0, 16'h0);
        rom[9'h70] = mw(3'd5, 9'h0, 3'd0, 16'h0);
        do_reset();
        run(10, 200);
        check("ret_len", 64'(trace.size()), 64'd4);
        if (trace.size() == 4) check("ret_target", 64'(trace[3]), 64'h11);
        check("ret_flags", {fault, halted}, 2'b01);

        // RET on empty stack
        clear_rom();
        rom[0] = mw(3'd5, 9'h0, 3'd0, 16'h0);
        do_reset();
        run(10, 200);
        check("unf_flags", {fault, halted}, 2'b11);

        // wrap from 511 and dispatch
        clear_rom();
        rom[0] = mw(3'd1, 9'h1FF, 3'd0, 16'h0);
        rom[9'h1FF] = mw(3'd0, 9'h0, 3'd0, 16'h0);
        do_reset();
        run(3, 200);
        check("wrap_len", 64'(trace.size()), 64'd3);
        if (trace.size() == 3) check("wrap_upc", 64'(trace[2]), 64'd0);

        clear_rom();
        rom[0] = mw(3'd6, 9'h0, 3'd0, 16'h0);
        dispatch_addr = 9'h1A5;
        do_reset();
        run(10, 200);
        check("disp_len", 64'(trace.size()), 64'd2);
        if (trace.size() == 2) check("disp_upc", 64'(trace[1]), 64'h1A5);
        dispatch_addr = 9'd0;

        // stall in EXEC, then stall in FETCH
        clear_rom();
        for (int i = 0; i < 4; i++) rom[i] = mw(3'd0, 9'd0, 3'd0, 16'h0);
        do_reset();
        edges = 0;
        while (!uinst_valid && edges < 20) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        check("stall_reach_exec", uinst_valid, 1'b1);
        stall = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!uinst_valid || !_rom_cs || !_rom_oe || upc != 9'd0) bad++;
        end
        check("stall_exec_hold", 64'(bad), 64'd0);
        stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("stall_release_fetch", {_rom_cs, uinst_valid, rom_addr}, {2'b00, 9'd1});
        stall = 1'b1;
        edges = 0;
        while (!uinst_valid && edges < 20) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        check("stall_fetch_timing", 64'(edges), 64'd3);
        check("stall_fetch_upc", upc, 9'd1);
        stall = 1'b0;

        // reset pulsed in the second wait cycle of the fetch of word 1
        do_reset();
        edges = 0;
        while (!(rom_addr == 9'd1 && !_rom_cs) && edges < 20) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
        @(posedge clk);
        @(negedge clk);
        check("inj_pre_cs", _rom_cs, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("inj_async_en", {_rom_cs, _rom_oe}, 2'b11);
        check("inj_async_addr", {rom_addr, upc}, 18'd0);
        @(negedge clk);
        reset = 1'b0;
        run(2, 200);
        check("inj_refetch_len", 64'(trace.size()), 64'd2);
        if (trace.size() == 2) check("inj_refetch_upc", 64'(trace[0]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
